fpu_ss_x_mem_responder: RTL and testbench

// Core-side responder for the cv-x-if memory interface driven by the FPU subsystem.
// It accepts x_mem_req_t transactions, checks alignment and size, and returns x_mem_resp_t in the handshake cycle.

---
 rtl/fpu_ss_x_mem_responder.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_fpu_ss_x_mem_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_x_mem_responder.sv
// rtl/fpu_ss_x_mem_responder.sv - cv-x-if memory responder bridging FPU loads/stores onto an OBI-style data bus
//
// The cv-x-if structs travel as flat packed vectors, MSB first:
//   x_mem_req_i    : {id, addr[31:0], mode[1:0], size[1:0], we, wdata, last, spec}
//   x_mem_resp_o   : {exc, exccode[5:0], dbg}
//   x_mem_result_o : {id, rdata, err, dbg}
// size encoding: 0 = byte, 1 = halfword, 2 = word, 3 = doubleword.

module fpu_ss_x_mem_responder #(
   parameter int X_ID_WIDTH      = 4,
   parameter int X_MEM_WIDTH     = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 x_mem_valid_i,
   output logic                                 x_mem_ready_o,
   input  logic [X_ID_WIDTH+X_MEM_WIDTH+38:0]   x_mem_req_i,
   output logic [7:0]                           x_mem_resp_o,
   output logic                                 x_mem_result_valid_o,
   output logic [X_ID_WIDTH+X_MEM_WIDTH+1:0]    x_mem_result_o,
   output logic                                 data_req_o,
   input  logic                                 data_gnt_i,
   output logic [31:0]                          data_addr_o,
   output logic                                 data_we_o,
   output logic [3:0]                           data_be_o,
   output logic [X_MEM_WIDTH-1:0]               data_wdata_o,
   input  logic                                 data_rvalid_i,
   input  logic [X_MEM_WIDTH-1:0]               data_rdata_i,
   input  logic                                 data_err_i
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int ENT_W = X_ID_WIDTH + 5;

   localparam logic [1:0] SIZE_BYTE   = 2'd0;
   localparam logic [1:0] SIZE_HALF   = 2'd1;
   localparam logic [1:0] SIZE_WORD   = 2'd2;
   localparam logic [1:0] SIZE_DOUBLE = 2'd3;

   localparam logic [5:0] EXC_LOAD_MISALIGNED  = 6'd4;
   localparam logic [5:0] EXC_LOAD_FAULT       = 6'd5;
   localparam logic [5:0] EXC_STORE_MISALIGNED = 6'd6;
   localparam logic [5:0] EXC_STORE_FAULT      = 6'd7;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   // Only a 32-bit data path and a non-empty FIFO are meaningful.
   if (X_MEM_WIDTH != 32) begin : g_bad_width
      $error("fpu_ss_x_mem_responder supports X_MEM_WIDTH == 32 only");
   end
   if (MAX_OUTSTANDING < 1) begin : g_bad_depth
      $error("fpu_ss_x_mem_responder needs MAX_OUTSTANDING >= 1");
   end

   // Request fields
   logic [X_ID_WIDTH-1:0]  req_id;
   logic [31:0]            req_addr;
   logic [1:0]             req_mode;
   logic [1:0]             req_size;
   logic                   req_we;
   logic [X_MEM_WIDTH-1:0] req_wdata;
   logic                   req_last;
   logic                   req_spec;

   assign req_spec  = x_mem_req_i[0];
   assign req_last  = x_mem_req_i[1];
   assign req_wdata = x_mem_req_i[X_MEM_WIDTH+1:2];
   assign req_we    = x_mem_req_i[X_MEM_WIDTH+2];
   assign req_size  = x_mem_req_i[X_MEM_WIDTH+4:X_MEM_WIDTH+3];
   assign req_mode  = x_mem_req_i[X_MEM_WIDTH+6:X_MEM_WIDTH+5];
   assign req_addr  = x_mem_req_i[X_MEM_WIDTH+38:X_MEM_WIDTH+7];
   assign req_id    = x_mem_req_i[X_ID_WIDTH+X_MEM_WIDTH+38:X_MEM_WIDTH+39];

   // mode, last and spec carry no meaning for this responder.
   logic unused_req_fields;
   assign unused_req_fields = ^{req_mode, req_last, req_spec};

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       out_cnt_q;
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [ENT_W-1:0]       fifo_q [MAX_OUTSTANDING];

   logic [X_ID_WIDTH-1:0]  lat_id_q;
   logic [31:0]            lat_addr_q;
   logic [1:0]             lat_size_q;
   logic                   lat_we_q;
   logic [3:0]             lat_be_q;
   logic [X_MEM_WIDTH-1:0] lat_wdata_q;

   logic                   res_valid_q;
   logic [X_ID_WIDTH-1:0]  res_id_q;
   logic [X_MEM_WIDTH-1:0] res_rdata_q;
   logic                   res_err_q;

   logic                   can_accept;
   logic                   handshake;
   logic                   accept;
   logic                   push;
   logic                   pop;
   logic                   misaligned;
   logic                   is_double;
   logic                   req_exc;
   logic [5:0]             req_exccode;
   logic [3:0]             fmt_be;
   logic [X_MEM_WIDTH-1:0] fmt_wdata;

   logic [ENT_W-1:0]       head;
   logic                   head_we;
   logic [1:0]             head_off;
   logic [1:0]             head_size;
   logic [X_ID_WIDTH-1:0]  head_id;
   logic [X_MEM_WIDTH-1:0] rdata_shifted;
   logic [X_MEM_WIDTH-1:0] rdata_fmt;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   // Acceptance is gated by reset so every output reads 0 while rst_ni is low.
   assign can_accept = rst_ni && (state_q == ST_IDLE) &&
                       (out_cnt_q < CNT_W'(MAX_OUTSTANDING));
   assign handshake  = x_mem_valid_i && can_accept;
   assign accept     = handshake && !req_exc;
   assign push       = (state_q == ST_PENDING) && data_gnt_i;
   // An rvalid with nothing outstanding has no owner and is dropped.
   assign pop        = data_rvalid_i && (out_cnt_q != '0);

   // Classify the incoming request: alignment and unsupported size.
   always_comb begin
      misaligned = 1'b0;
      is_double  = 1'b0;
      case (req_size)
         SIZE_HALF:   misaligned = req_addr[0];
         SIZE_WORD:   misaligned = (req_addr[1:0] != 2'b00);
         SIZE_DOUBLE: is_double  = 1'b1;
         default:     misaligned = 1'b0;
      endcase
      req_exc = misaligned || is_double;
      if (is_double) begin
         req_exccode = req_we ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
      end else begin
         req_exccode = req_we ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
      end
   end

   // Lane-align byte enables and replicate narrow store data across the word.
   always_comb begin
      fmt_be    = 4'b1111;
      fmt_wdata = req_wdata;
      case (req_size)
         SIZE_BYTE: begin
            fmt_be    = 4'b0001 << req_addr[1:0];
            fmt_wdata = {4{req_wdata[7:0]}};
         end
         SIZE_HALF: begin
            fmt_be    = 4'b0011 << req_addr[1:0];
            fmt_wdata = {2{req_wdata[15:0]}};
         end
         default: begin
            fmt_be    = 4'b1111;
            fmt_wdata = req_wdata;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: a legal request opens a bus access, a grant closes it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (accept) state_d = ST_PENDING;
         ST_PENDING: if (data_gnt_i) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: handshake response in IDLE, held bus request in PENDING.
   always_comb begin
      x_mem_ready_o = 1'b0;
      x_mem_resp_o  = 8'h00;
      data_req_o    = 1'b0;
      data_addr_o   = 32'h0;
      data_we_o     = 1'b0;
      data_be_o     = 4'h0;
      data_wdata_o  = '0;
      case (state_q)
         ST_IDLE: begin
            x_mem_ready_o = can_accept;
            if (handshake && req_exc) begin
               x_mem_resp_o = {1'b1, req_exccode, 1'b0};
            end
         end
         ST_PENDING: begin
            data_req_o   = 1'b1;
            data_addr_o  = lat_addr_q;
            data_we_o    = lat_we_q;
            data_be_o    = lat_be_q;
            data_wdata_o = lat_wdata_q;
         end
         default: data_req_o = 1'b0;
      endcase
   end

   // Capture an accepted request so the bus sees stable values until grant.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lat_id_q    <= '0;
         lat_addr_q  <= '0;
         lat_size_q  <= '0;
         lat_we_q    <= 1'b0;
         lat_be_q    <= '0;
         lat_wdata_q <= '0;
      end else if (accept) begin
         lat_id_q    <= req_id;
         lat_addr_q  <= req_addr;
         lat_size_q  <= req_size;
         lat_we_q    <= req_we;
         lat_be_q    <= fmt_be;
         lat_wdata_q <= fmt_wdata;
      end
   end

   // Metadata FIFO of granted accesses and the outstanding counter that tracks its fill.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         out_cnt_q <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= {lat_id_q, lat_size_q, lat_addr_q[1:0], lat_we_q};
            wr_ptr_q         <= ptr_next(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_next(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
            2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
            default: out_cnt_q <= out_cnt_q;
         endcase
      end
   end

   assign head      = fifo_q[rd_ptr_q];
   assign head_we   = head[0];
   assign head_off  = head[2:1];
   assign head_size = head[4:3];
   assign head_id   = head[ENT_W-1:5];

   assign rdata_shifted = data_rdata_i >> {head_off, 3'b000};

   // Extract the addressed lane of the returned word; stores return zero.
   always_comb begin
      case (head_size)
         SIZE_BYTE: rdata_fmt = {24'h0, rdata_shifted[7:0]};
         SIZE_HALF: rdata_fmt = {16'h0, rdata_shifted[15:0]};
         default:   rdata_fmt = rdata_shifted;
      endcase
      if (head_we) begin
         rdata_fmt = '0;
      end
   end

   // Result stage: one-cycle pulse registered from the bus response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_rdata_q <= '0;
         res_err_q   <= 1'b0;
      end else begin
         res_valid_q <= pop;
         if (pop) begin
            res_id_q    <= head_id;
            res_rdata_q <= rdata_fmt;
            res_err_q   <= data_err_i;
         end
      end
   end

   assign x_mem_result_valid_o = res_valid_q;
   assign x_mem_result_o       = res_valid_q ? {res_id_q, res_rdata_q, res_err_q, 1'b0} : '0;

   // Flag bus responses that arrive with nothing outstanding.
   always_ff @(posedge clk_i) begin
      if (rst_ni && data_rvalid_i) begin
         assert (out_cnt_q != '0)
            else $warning("stray data_rvalid_i with nothing outstanding, ignored");
      end
   end

endmodule

// File: tb/tb_fpu_ss_x_mem_responder.sv
// tb/tb_fpu_ss_x_mem_responder.sv - directed self-checking bench for fpu_ss_x_mem_responder

module tb_fpu_ss_x_mem_responder;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        x_mem_valid;
   logic        x_mem_ready;
   logic [74:0] x_mem_req;
   logic [7:0]  x_mem_resp;
   logic        x_mem_result_valid;
   logic [37:0] x_mem_result;
   logic        data_req;
   logic        data_gnt;
   logic [31:0] data_addr;
   logic        data_we;
   logic [3:0]  data_be;
   logic [31:0] data_wdata;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        data_err;

   int tests_run    = 0;
   int tests_failed = 0;

   fpu_ss_x_mem_responder #(
      .X_ID_WIDTH      (4),
      .X_MEM_WIDTH     (32),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk_i                (clk),
      .rst_ni               (rst_n),
      .x_mem_valid_i        (x_mem_valid),
      .x_mem_ready_o        (x_mem_ready),
      .x_mem_req_i          (x_mem_req),
      .x_mem_resp_o         (x_mem_resp),
      .x_mem_result_valid_o (x_mem_result_valid),
      .x_mem_result_o       (x_mem_result),
      .data_req_o           (data_req),
      .data_gnt_i           (data_gnt),
      .data_addr_o          (data_addr),
      .data_we_o            (data_we),
      .data_be_o            (data_be),
      .data_wdata_o         (data_wdata),
      .data_rvalid_i        (data_rvalid),
      .data_rdata_i         (data_rdata),
      .data_err_i           (data_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [3:0] id, input logic [31:0] addr,
                            input logic [1:0] sz, input logic we, input logic [31:0] wd);
      x_mem_valid = 1'b1;
      // mode/last/spec set to non-zero to show they are ignored
      x_mem_req   = {id, addr, 2'b11, sz, we, wd, 1'b1, 1'b1};
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_ready"},   x_mem_ready, 0);
      check({pfx, "_resp"},    x_mem_resp, 0);
      check({pfx, "_rvalid"},  x_mem_result_valid, 0);
      check({pfx, "_result"},  x_mem_result, 0);
      check({pfx, "_req"},     data_req, 0);
      check({pfx, "_addr"},    data_addr, 0);
      check({pfx, "_we"},      data_we, 0);
      check({pfx, "_be"},      data_be, 0);
      check({pfx, "_wdata"},   data_wdata, 0);
   endtask

   // Legal request: handshake, check the held bus beat, grant after pend cycles.
   task automatic issue(input string tag, input logic [3:0] id, input logic [31:0] addr,
                        input logic [1:0] sz, input logic we, input logic [31:0] wd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input int pend, input logic rv, input logic [31:0] rv_data);
      drive_req(id, addr, sz, we, wd);
      #1;
      check({tag, "_hs_ready"}, x_mem_ready, 1);
      check({tag, "_hs_resp"}, x_mem_resp, 0);
      step();
      x_mem_valid = 1'b0;
      x_mem_req   = '0;
      for (int c = 1; c <= pend; c++) begin
         #1;
         check({tag, "_req"}, data_req, 1);
         check({tag, "_busy"}, x_mem_ready, 0);
         check({tag, "_addr"}, data_addr, addr);
         check({tag, "_we"}, data_we, we);
         check({tag, "_be"}, data_be, exp_be);
         check({tag, "_wdata"}, data_wdata, exp_wd);
         if (c == pend) begin
            data_gnt = 1'b1;
            if (rv) begin
               data_rvalid = 1'b1;
               data_rdata  = rv_data;
               data_err    = 1'b0;
            end
         end
         step();
      end
      data_gnt    = 1'b0;
      data_rvalid = 1'b0;
      data_rdata  = '0;
      #1;
      check({tag, "_req_drop"}, data_req, 0);
   endtask

   task automatic respond(input logic [31:0] rd, input logic err);
      data_rvalid = 1'b1;
      data_rdata  = rd;
      data_err    = err;
      #1;
      step();
      data_rvalid = 1'b0;
      data_rdata  = '0;
      data_err    = 1'b0;
      #1;
   endtask

   task automatic check_result(input string tag, input logic [3:0] id,
                               input logic [31:0] rd, input logic err);
      check({tag, "_valid"}, x_mem_result_valid, 1);
      check({tag, "_id"},    x_mem_result[37:34], id);
      check({tag, "_rdata"}, x_mem_result[33:2], rd);
      check({tag, "_err"},   x_mem_result[1], err);
      check({tag, "_dbg"},   x_mem_result[0], 0);
   endtask

   task automatic exc_req(input string tag, input logic [3:0] id, input logic [31:0] addr,
                          input logic [1:0] sz, input logic we, input logic [7:0] exp_resp);
      drive_req(id, addr, sz, we, 32'h1234_5678);
      #1;
      check({tag, "_ready"}, x_mem_ready, 1);
      check({tag, "_resp"}, x_mem_resp, exp_resp);
      step();
      x_mem_valid = 1'b0;
      x_mem_req   = '0;
      #1;
      check({tag, "_noreq"}, data_req, 0);
      check({tag, "_idle"}, x_mem_ready, 1);
   endtask

   initial begin
      rst_n       = 1'b0;
      x_mem_valid = 1'b0;
      x_mem_req   = '0;
      data_gnt    = 1'b0;
      data_rvalid = 1'b0;
      data_rdata  = '0;
      data_err    = 1'b0;
      #2;
      check_all_zero("reset");
      step();
      step();
      rst_n = 1'b1;
      #1;
      check("post_reset_ready", x_mem_ready, 1);
      check("post_reset_req", data_req, 0);

      // 1: word load, grant in the second PENDING cycle
      issue("wl", 4'd5, 32'h100, SZ_W, 1'b0, 32'h0, 4'hF, 32'h0, 2, 1'b0, 32'h0);
      check("wl_no_early_result", x_mem_result_valid, 0);
      respond(32'hDEAD_BEEF, 1'b0);
      check_result("wl_res", 4'd5, 32'hDEAD_BEEF, 1'b0);
      step();
      check("wl_pulse_end", x_mem_result_valid, 0);

      // 2: narrow accesses and lane handling
      issue("bs", 4'd2, 32'h203, SZ_B, 1'b1, 32'h5A, 4'b1000, 32'h5A5A_5A5A, 1, 1'b0, 32'h0);
      respond(32'h1234_5678, 1'b0);
      check_result("bs_res", 4'd2, 32'h0, 1'b0);
      issue("hl", 4'd9, 32'h202, SZ_H, 1'b0, 32'h0, 4'b1100, 32'h0, 1, 1'b0, 32'h0);
      respond(32'hABCD_1234, 1'b0);
      check_result("hl_res", 4'd9, 32'h0000_ABCD, 1'b0);
      issue("bl", 4'd6, 32'h201, SZ_B, 1'b0, 32'h0, 4'b0010, 32'h0, 1, 1'b0, 32'h0);
      respond(32'h1122_3344, 1'b0);
      check_result("bl_res", 4'd6, 32'h0000_0033, 1'b0);
      issue("hs", 4'd8, 32'h202, SZ_H, 1'b1, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 1, 1'b0, 32'h0);
      respond(32'hFFFF_FFFF, 1'b0);
      check_result("hs_res", 4'd8, 32'h0, 1'b0);

      // 3: exceptions, resp = {exc, exccode, dbg}
      exc_req("mis_wl", 4'd1, 32'h101, SZ_W, 1'b0, {1'b1, 6'd4, 1'b0});
      exc_req("mis_ws", 4'd1, 32'h101, SZ_W, 1'b1, {1'b1, 6'd6, 1'b0});
      exc_req("dbl_s",  4'd2, 32'h108, SZ_D, 1'b1, {1'b1, 6'd7, 1'b0});
      exc_req("dbl_l",  4'd3, 32'h108, SZ_D, 1'b0, {1'b1, 6'd5, 1'b0});
      exc_req("mis_hl", 4'd4, 32'h103, SZ_H, 1'b0, {1'b1, 6'd4, 1'b0});
      step();
      check("exc_no_result", x_mem_result_valid, 0);
      check("exc_no_bus", data_req, 0);

      // 4: fill to MAX_OUTSTANDING, then drain in order
      issue("o3", 4'd3, 32'h300, SZ_W, 1'b0, 32'h0, 4'hF, 32'h0, 1, 1'b0, 32'h0);
      issue("o7", 4'd7, 32'h304, SZ_W, 1'b0, 32'h0, 4'hF, 32'h0, 1, 1'b0, 32'h0);
      check("full_ready", x_mem_ready, 0);
      drive_req(4'd1, 32'h308, SZ_W, 1'b0, 32'h0);
      #1;
      check("full_resp", x_mem_resp, 0);
      step();
      x_mem_valid = 1'b0;
      x_mem_req   = '0;
      #1;
      check("full_no_req", data_req, 0);
      respond(32'h3333_3333, 1'b0);
      check_result("o3_res", 4'd3, 32'h3333_3333, 1'b0);
      check("drain_ready", x_mem_ready, 1);
      respond(32'h7777_7777, 1'b0);
      check_result("o7_res", 4'd7, 32'h7777_7777, 1'b0);

      // 5: bus error, then grant and rvalid in the same cycle
      issue("er", 4'hA, 32'h400, SZ_W, 1'b0, 32'h0, 4'hF, 32'h0, 1, 1'b0, 32'h0);
      respond(32'h0BAD_0BAD, 1'b1);
      check_result("er_res", 4'hA, 32'h0BAD_0BAD, 1'b1);
      issue("sc1", 4'd1, 32'h500, SZ_W, 1'b0, 32'h0, 4'hF, 32'h0, 1, 1'b0, 32'h0);
      issue("sc2", 4'd2, 32'h504, SZ_W, 1'b0, 32'h0, 4'hF, 32'h0, 1, 1'b1, 32'hCAFE_F00D);
      check_result("sc1_res", 4'd1, 32'hCAFE_F00D, 1'b0);
      check("sc_ready", x_mem_ready, 1);
      issue("sc3", 4'd3, 32'h508, SZ_W, 1'b0, 32'h0, 4'hF, 32'h0, 1, 1'b0, 32'h0);
      check("sc_cnt_full", x_mem_ready, 0);
      respond(32'h2222_2222, 1'b0);
      check_result("sc2_res", 4'd2, 32'h2222_2222, 1'b0);
      respond(32'h3333_0000, 1'b0);
      check_result("sc3_res", 4'd3, 32'h3333_0000, 1'b0);

      // 6: asynchronous reset while PENDING with one outstanding
      issue("r4", 4'd4, 32'h600, SZ_W, 1'b0, 32'h0, 4'hF, 32'h0, 1, 1'b0, 32'h0);
      drive_req(4'd5, 32'h604, SZ_W, 1'b1, 32'h5555_5555);
      step();
      x_mem_valid = 1'b0;
      x_mem_req   = '0;
      #1;
      check("rst_pending", data_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      step();
      step();
      rst_n = 1'b1;
      #1;
      check("rst_rel_ready", x_mem_ready, 1);
      respond(32'h4444_4444, 1'b0);
      check("stray_valid", x_mem_result_valid, 0);
      check("stray_result", x_mem_result, 0);
      step();
      check("stray_idle_req", data_req, 0);
      check("stray_idle_ready", x_mem_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
